// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Types and defaults shared by the vote button qualifier and the tally block.
//   vote_state_e     : qualifier FSM states
//   VOTE_N_CH        : default number of candidate buttons
//   VOTE_HOLD_CYCLES : default number of consecutive held cycles for one vote
// -----------------------------------------------------------------------------
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    FIRE     = 2'd2,
    WAIT_REL = 2'd3
  } vote_state_e;

  localparam int VOTE_N_CH        = 4;
  localparam int VOTE_HOLD_CYCLES = 100_000_000;

endpackage : vote_pkg

// File: rtl/button_sync.sv
// -----------------------------------------------------------------------------
// button_sync
// Single-bit multi-flop synchroniser for one raw, asynchronous button.
//   clk   : system clock
//   rst   : asynchronous active-low reset, clears every stage
//   d_i   : raw asynchronous input
//   q_o   : synchronised output, SYNC_STAGES cycles behind d_i
// -----------------------------------------------------------------------------
module button_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  // NOTE: every stage is reset so a button held through reset is seen as a
  // fresh press rather than as a level that was already there.
  // NOTE: non-blocking assignment so each stage samples the previous stage's
  // value from before the edge; blocking would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule : button_sync

// File: rtl/vote_button_qualifier.sv
// -----------------------------------------------------------------------------
// vote_button_qualifier
// Qualifies one vote from N_CH candidate buttons: exactly one button must be
// held for HOLD_CYCLES consecutive synchronised cycles. One pulse per press;
// all buttons must be released before another vote can start.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   en         : polls open; low blocks new holds and aborts a running hold
//   button     : raw asynchronous buttons, active-high
//   vote_valid : one-cycle pulse, vote accepted
//   vote_ch    : channel of the last accepted vote
//   conflict   : one-cycle pulse, hold aborted (second button or en low)
//   busy       : FSM is not in IDLE
// -----------------------------------------------------------------------------
module vote_button_qualifier
  import vote_pkg::*;
#(
  parameter  int N_CH        = VOTE_N_CH,
  parameter  int HOLD_CYCLES = VOTE_HOLD_CYCLES,
  parameter  int SYNC_STAGES = 2,
  localparam int CH_W        = $clog2(N_CH),
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] button,
  output logic            vote_valid,
  output logic [CH_W-1:0] vote_ch,
  output logic            conflict,
  output logic            busy
);

  // ---------------------------------------------------------------------------
  // Synchronisers
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0] bs;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    button_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_button_sync (
      .clk (clk),
      .rst (rst),
      .d_i (button[g]),
      .q_o (bs[g])
    );
  end

  // ---------------------------------------------------------------------------
  // One-hot detection and channel encode of the synchronised vector
  // ---------------------------------------------------------------------------
  logic            bs_any;
  logic            bs_onehot;
  logic [CH_W-1:0] bs_idx;

  always_comb begin
    bs_any    = |bs;
    // Clearing the lowest set bit leaves zero only for a single set bit.
    bs_onehot = bs_any && ((bs & (bs - N_CH'(1))) == '0);
    bs_idx    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (bs[i]) bs_idx = CH_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, hold counter and captured channel
  // ---------------------------------------------------------------------------
  vote_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  cap_q, cap_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             fire_d;
  logic             conflict_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    ch_d       = ch_q;
    fire_d     = 1'b0;
    conflict_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en && bs_onehot) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(1);
          cap_d   = bs;
          ch_d    = bs_idx;
        end else if (en && bs_any) begin
          state_d = WAIT_REL;
        end
      end

      HOLD: begin
        // Abort is checked first so it wins over a simultaneous release.
        if (!en || ((bs & ~cap_q) != '0)) begin
          state_d    = WAIT_REL;
          cnt_d      = '0;
          conflict_d = 1'b1;
        end else if (bs == cap_q) begin
          if (cnt_q < CNT_W'(HOLD_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q >= CNT_W'(HOLD_CYCLES - 1)) begin
            state_d = FIRE;
            fire_d  = 1'b1;
          end
        end else begin
          // Short press: captured button released early, nothing else held.
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      FIRE: begin
        state_d = WAIT_REL;
        cnt_d   = '0;
      end

      WAIT_REL: begin
        if (!bs_any) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  logic            vote_valid_q;
  logic [CH_W-1:0] vote_ch_q;
  logic            conflict_q;
  logic            busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cap_q        <= '0;
      ch_q         <= '0;
      vote_valid_q <= 1'b0;
      vote_ch_q    <= '0;
      conflict_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      ch_q         <= ch_d;
      vote_valid_q <= fire_d;
      conflict_q   <= conflict_d;
      busy_q       <= (state_d != IDLE);
      if (fire_d) vote_ch_q <= ch_q;
    end
  end

  assign vote_valid = vote_valid_q;
  assign vote_ch    = vote_ch_q;
  assign conflict   = conflict_q;
  assign busy       = busy_q;

endmodule : vote_button_qualifier
